// File: rtl/obstacle_scheduler_if.sv
// Signal bundle between obstacle_scheduler and the game datapath
// (frame timing, game status in; obstacle mux select and status out).
`timescale 1ns/1ps

interface obstacle_scheduler_if;
    logic       vsync_in;
    logic       play_selected;
    logic       game_over;
    logic       obstacle_done;
    logic [3:0] select;
    logic       obstacle_active;
    logic       obstacle_start;
    logic [7:0] round_count;

    // master: the scheduler itself; slave: the surrounding game logic
    modport master (
        input  vsync_in, play_selected, game_over, obstacle_done,
        output select, obstacle_active, obstacle_start, round_count
    );
    modport slave (
        output vsync_in, play_selected, game_over, obstacle_done,
        input  select, obstacle_active, obstacle_start, round_count
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Frame-based obstacle sequencer: drives the obstacle mux select through GAP/ACTIVE phases.
// Optional macro SCHED_RANDOM_EN selects a pseudo-random (non-repeating) obstacle order.
`timescale 1ns/1ps

module obstacle_scheduler #(
    parameter int NUM_OBSTACLES   = 2,
    parameter int OBSTACLE_FRAMES = 600,
    parameter int GAP_FRAMES      = 60,
    parameter int IDLE_SEL        = 0
) (
    input  logic                  pclk,
    input  logic                  rst,
    obstacle_scheduler_if.master  bus
);

    typedef enum logic [1:0] {IDLE, GAP, ACTIVE, STOPPED} state_t;

    // A zero frame count behaves as a single frame.
    localparam logic [15:0] GAP_LAST = (GAP_FRAMES      == 0) ? 16'd0 : 16'(GAP_FRAMES - 1);
    localparam logic [15:0] OBS_LAST = (OBSTACLE_FRAMES == 0) ? 16'd0 : 16'(OBSTACLE_FRAMES - 1);
    localparam logic [3:0]  LAST_IDX = 4'(NUM_OBSTACLES - 1);
    localparam logic [3:0]  IDLE_VAL = 4'(IDLE_SEL);

    state_t      state_q, state_d;
    logic [3:0]  index_q, index_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  round_q, round_d;
    logic [3:0]  select_q, select_d;
    logic        active_q, active_d;
    logic        start_q, start_d;
    logic        vsync_prev_q;
    logic        tick;
    logic        advance;
    logic [3:0]  seq_next;

`ifdef SCHED_RANDOM_EN
    logic [7:0]  lfsr_q, lfsr_d;
    logic [3:0]  done_cnt_q, done_cnt_d;
    logic [4:0]  cand;
`endif

    assign tick     = bus.vsync_in & ~vsync_prev_q;
    assign seq_next = (index_q == LAST_IDX) ? 4'd0 : index_q + 4'd1;

    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        advance = 1'b0;
`ifdef SCHED_RANDOM_EN
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        done_cnt_d = done_cnt_q;
        cand       = {1'b0, lfsr_q[3:0]} % 5'(NUM_OBSTACLES);
`endif

        if (bus.game_over) begin
            state_d = STOPPED;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.play_selected) begin
                        state_d = GAP;
                        cnt_d   = 16'd0;
                        index_d = 4'd0;
                        round_d = 8'd0;
`ifdef SCHED_RANDOM_EN
                        done_cnt_d = 4'd0;
`endif
                    end
                end
                GAP: begin
                    if (!bus.play_selected) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        if (cnt_q == GAP_LAST) begin
                            state_d = ACTIVE;
                            cnt_d   = 16'd0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                ACTIVE: begin
                    if (!bus.play_selected) begin
                        state_d = IDLE;
                    end else if (bus.obstacle_done || (tick && cnt_q == OBS_LAST)) begin
                        state_d = GAP;
                        cnt_d   = 16'd0;
                        advance = 1'b1;
                    end else if (tick) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                STOPPED: begin
                    if (!bus.play_selected) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (advance) begin
`ifdef SCHED_RANDOM_EN
            // Never repeat the same obstacle back-to-back.
            index_d = (NUM_OBSTACLES > 1 && cand[3:0] == index_q) ? seq_next : cand[3:0];
            if (done_cnt_q == LAST_IDX) begin
                done_cnt_d = 4'd0;
                if (round_q != 8'hFF) round_d = round_q + 8'd1;
            end else begin
                done_cnt_d = done_cnt_q + 4'd1;
            end
`else
            index_d = seq_next;
            if (index_q == LAST_IDX && round_q != 8'hFF) round_d = round_q + 8'd1;
`endif
        end

        // Outputs are registered from the next state so they line up with state_q.
        if (state_d == IDLE)         select_d = IDLE_VAL;
        else if (state_d == STOPPED) select_d = select_q;
        else                         select_d = index_d;
        active_d = (state_d == ACTIVE);
        start_d  = (state_q == GAP) && (state_d == ACTIVE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            index_q      <= 4'd0;
            cnt_q        <= 16'd0;
            round_q      <= 8'd0;
            select_q     <= IDLE_VAL;
            active_q     <= 1'b0;
            start_q      <= 1'b0;
            vsync_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            cnt_q        <= cnt_d;
            round_q      <= round_d;
            select_q     <= select_d;
            active_q     <= active_d;
            start_q      <= start_d;
            vsync_prev_q <= bus.vsync_in;
        end
    end

`ifdef SCHED_RANDOM_EN
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            lfsr_q     <= 8'hA5;
            done_cnt_q <= 4'd0;
        end else begin
            lfsr_q     <= lfsr_d;
            done_cnt_q <= done_cnt_d;
        end
    end
`endif

    assign bus.select          = select_q;
    assign bus.obstacle_active = active_q;
    assign bus.obstacle_start  = start_q;
    assign bus.round_count     = round_q;

endmodule
